// File: rtl/i2c_cmd_sequencer.sv
// Queues byte-level I2C commands and drives the i2c master's enable/address/data
// inputs one command at a time, returning one response (data + error) per command.
module i2c_cmd_sequencer #(
    parameter int CMD_DEPTH  = 4,
    parameter int EN_CYCLES  = 2,
    parameter int WR_CYCLES  = 52,
    parameter int RD_TIMEOUT = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic       read,
    output logic [6:0] slave_address,
    output logic [7:0] data_send_master,
    output logic       data_send_master_enable,
    input  logic [7:0] data_receive_master,
    input  logic       data_receive_master_enable,
    input  logic       error_master,
    output logic       busy
);
    localparam int PW   = $clog2(CMD_DEPTH);
    localparam int CMAX = (RD_TIMEOUT > WR_CYCLES)
                          ? ((RD_TIMEOUT > EN_CYCLES) ? RD_TIMEOUT : EN_CYCLES)
                          : ((WR_CYCLES  > EN_CYCLES) ? WR_CYCLES  : EN_CYCLES);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // FIFO entry layout: {read, addr[6:0], data[7:0]}
    logic [15:0]   r_mem [CMD_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_full, w_push, w_pop;
    logic [15:0]   w_head;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_read, w_read_nxt;
    logic [6:0]    r_addr, w_addr_nxt;
    logic [7:0]    r_wdata, w_wdata_nxt;
    logic          r_en, w_en_nxt;
    logic [7:0]    r_rdata, w_rdata_nxt;
    logic          r_err, w_err_nxt;

    assign w_full  = (r_count == (PW+1)'(CMD_DEPTH));
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd_read, cmd_addr, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_read_nxt  = r_read;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_en_nxt    = r_en;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                w_read_nxt  = 1'b0;
                w_addr_nxt  = '0;
                w_wdata_nxt = '0;
                w_en_nxt    = 1'b0;
                if (w_pop) begin
                    {w_read_nxt, w_addr_nxt, w_wdata_nxt} = w_head;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (error_master) begin
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CW'(EN_CYCLES - 1)) begin
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                // A master error still lets a simultaneous read byte through to rsp_data
                if (error_master) begin
                    w_rdata_nxt = (r_read && data_receive_master_enable) ? data_receive_master : 8'h00;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_read && data_receive_master_enable) begin
                    w_rdata_nxt = data_receive_master;
                    w_state_nxt = S_RESP;
                end else if (r_read && w_cnt_inc == CW'(RD_TIMEOUT)) begin
                    w_rdata_nxt = 8'h00;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (!r_read && w_cnt_inc == CW'(WR_CYCLES)) begin
                    w_rdata_nxt = 8'h00;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rdata_nxt = 8'h00;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_RESP) begin
            w_read_nxt  = 1'b0;
            w_addr_nxt  = '0;
            w_wdata_nxt = '0;
            w_en_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_en    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_read  <= w_read_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_en    <= w_en_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign cmd_ready               = !w_full;
    assign rsp_valid               = (r_state == S_RESP);
    assign rsp_data                = r_rdata;
    assign rsp_error               = r_err;
    assign read                    = r_read;
    assign slave_address           = r_addr;
    assign data_send_master        = r_wdata;
    assign data_send_master_enable = r_en;
    assign busy                    = (r_state != S_IDLE) || (r_count != '0);
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: a table of single commands with a scripted
// master response, then hand sequences for FIFO fill, response ordering and reset.
module tb_i2c_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_read;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_error;
    logic [7:0] rsp_data;
    logic       read, en, drme, error_master, busy;
    logic [6:0] slave_address;
    logic [7:0] data_send_master, drm;

    logic       tb_drme, am_drme, auto_master;
    logic [7:0] tb_drm, am_data;
    logic [6:0] am_addr;
    int         am_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign drme = tb_drme | am_drme;
    assign drm  = auto_master ? am_data : tb_drm;
    assign am_data = {1'b0, am_addr} ^ 8'h5A;

    i2c_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error),
        .read(read), .slave_address(slave_address),
        .data_send_master(data_send_master), .data_send_master_enable(en),
        .data_receive_master(drm), .data_receive_master_enable(drme),
        .error_master(error_master), .busy(busy)
    );

    // Simple master: answers each read a few cycles after enable with addr ^ 0x5A
    always @(posedge clk) begin
        #1;
        am_drme = 1'b0;
        if (!auto_master) am_cnt = 0;
        else if (en) begin
            am_cnt  = 1;
            am_addr = slave_address;
        end else if (am_cnt != 0) begin
            am_cnt++;
            if (am_cnt == 4) begin
                am_drme = 1'b1;
                am_cnt  = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       drme;
        logic       err;
        int         d;
        logic [7:0] rdata;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int w, width, accepted, ng;
        logic ok, held, stable, sixth, errs, bad;
        logic [7:0] got[8];

        // rd addr wdata drme err d rdata | exp_data exp_err exp_lat (WAIT cycles to rsp_valid)
        vecs[0] = '{1'b0, 7'h4B, 8'h93, 1'b0, 1'b0,  0, 8'h00, 8'h00, 1'b0,  52};
        vecs[1] = '{1'b1, 7'h4B, 8'h00, 1'b1, 1'b0, 28, 8'h93, 8'h93, 1'b0,  29};
        vecs[2] = '{1'b0, 7'h12, 8'hA5, 1'b0, 1'b1, 10, 8'h00, 8'h00, 1'b1,  11};
        vecs[3] = '{1'b1, 7'h7F, 8'h00, 1'b0, 1'b0,  0, 8'h00, 8'h00, 1'b1, 128};
        vecs[4] = '{1'b1, 7'h01, 8'h00, 1'b1, 1'b1,  0, 8'h5A, 8'h5A, 1'b1,   1};
        vecs[5] = '{1'b1, 7'h22, 8'h00, 1'b1, 1'b0,  5, 8'hC3, 8'hC3, 1'b0,   6};
        vecs[6] = '{1'b0, 7'h33, 8'h0F, 1'b1, 1'b0,  3, 8'hEE, 8'h00, 1'b0,  52};

        rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; tb_drme = 1'b0; tb_drm = '0; error_master = 1'b0;
        auto_master = 1'b0; am_drme = 1'b0; am_addr = '0; am_cnt = 0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_master",    32'({en, read, slave_address, data_send_master}), 32'd0);

        foreach (vecs[i]) begin
            cmd_read = vecs[i].rd; cmd_addr = vecs[i].addr; cmd_data = vecs[i].wdata;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            check($sformatf("v%0d_en_lat", i), 32'(en), 32'd0);
            tick();
            width = 0; ok = 1'b1;
            while (en && width < 10) begin
                if (slave_address !== vecs[i].addr || data_send_master !== vecs[i].wdata ||
                    read !== vecs[i].rd) ok = 1'b0;
                width++;
                tick();
            end
            check($sformatf("v%0d_en_width", i), 32'(width), 32'd2);
            check($sformatf("v%0d_issue_fields", i), 32'(ok), 32'd1);
            w = 0; held = 1'b1;
            while (!rsp_valid && w < 300) begin
                tb_drme      = vecs[i].drme && (w == vecs[i].d);
                tb_drm       = vecs[i].rdata;
                error_master = vecs[i].err && (w == vecs[i].d);
                if (read !== vecs[i].rd || slave_address !== vecs[i].addr || en !== 1'b0) held = 1'b0;
                tick();
                tb_drme = 1'b0; error_master = 1'b0;
                w++;
            end
            check($sformatf("v%0d_rsp_latency", i), 32'(w), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_rsp_error", i), 32'(rsp_error), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_wait_held", i), 32'(held), 32'd1);
            check($sformatf("v%0d_resp_master_zero", i),
                  32'({en, read, slave_address, data_send_master}), 32'd0);
            stable = 1'b1;
            repeat (5) begin
                tick();
                if (rsp_valid !== 1'b1 || rsp_data !== vecs[i].exp_data ||
                    rsp_error !== vecs[i].exp_err || busy !== 1'b1 || en !== 1'b0) stable = 1'b0;
            end
            check($sformatf("v%0d_rsp_hold", i), 32'(stable), 32'd1);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check($sformatf("v%0d_rsp_done", i), 32'({rsp_valid, rsp_data, rsp_error}), 32'd0);
        end

        // Fill: one command is popped immediately, four more fill the FIFO
        auto_master = 1'b1;
        cmd_read = 1'b1; cmd_data = '0; cmd_valid = 1'b1; accepted = 0;
        for (int k = 0; k < 10 && cmd_ready; k++) begin
            cmd_addr = 7'h10 + 7'(accepted);
            tick();
            accepted++;
        end
        cmd_valid = 1'b0;
        check("fill_accepted", 32'(accepted), 32'd5);
        check("fill_ready_low", 32'(cmd_ready), 32'd0);
        cmd_addr = 7'h15; cmd_valid = 1'b1; rsp_ready = 1'b1;
        ng = 0; sixth = 1'b0; errs = 1'b0;
        for (int k = 0; k < 2000 && ng < 6; k++) begin
            ok = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                got[ng] = rsp_data;
                if (rsp_error) errs = 1'b1;
                ng++;
            end
            tick();
            if (ok) begin
                cmd_valid = 1'b0;
                sixth = 1'b1;
            end
        end
        rsp_ready = 1'b0;
        check("fill_sixth_accepted", 32'(sixth), 32'd1);
        check("fill_rsp_count", 32'(ng), 32'd6);
        check("fill_rsp_errors", 32'(errs), 32'd0);
        for (int k = 0; k < 6; k++)
            check($sformatf("fill_rsp%0d_order", k), 32'(got[k]),
                  32'({1'b0, 7'h10 + 7'(k)} ^ 8'h5A));
        auto_master = 1'b0;
        repeat (3) tick();

        // Reset in ISSUE with three commands still queued
        cmd_read = 1'b0; cmd_addr = 7'h20; cmd_data = 8'h11; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 200 && !rsp_valid; k++) tick();
        check("rst_seq_first_rsp", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1;
        repeat (4) tick();
        cmd_valid = 1'b0;
        check("rst_seq_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        check("rst_seq_in_issue", 32'(en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_seq_en", 32'(en), 32'd0);
        check("rst_seq_busy", 32'(busy), 32'd0);
        check("rst_seq_ready", 32'(cmd_ready), 32'd1);
        bad = 1'b0;
        repeat (300) begin
            tick();
            if (en || rsp_valid || busy) bad = 1'b1;
        end
        check("rst_seq_quiet", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
